// File: rtl/ex_mem_if.sv
// Execute-to-memory handshake bundle: upstream instruction/ALU inputs,
// stall back-pressure and the registered memory-stage payload.
interface ex_mem_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [3:0]        in_op;
  logic [3:0]        in_rd;
  logic [DATA_W-1:0] in_store_data;
  logic [DATA_W-1:0] in_target;
  logic [DATA_W-1:0] alu_out;
  logic              zero;
  logic              negative;
  logic              carry;
  logic              stall;
  logic              in_ready;

  logic              out_valid;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic [3:0]        out_rd;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store_data;

  // Upstream/testbench side
  modport master (
    output in_valid, in_op, in_rd, in_store_data, in_target,
    output alu_out, zero, negative, carry, stall,
    input  in_ready,
    input  out_valid, out_reg_write, out_mem_read, out_mem_write,
    input  out_rd, out_result, out_store_data
  );

  // Pipeline stage side
  modport slave (
    input  in_valid, in_op, in_rd, in_store_data, in_target,
    input  alu_out, zero, negative, carry, stall,
    output in_ready,
    output out_valid, out_reg_write, out_mem_read, out_mem_write,
    output out_rd, out_result, out_store_data
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag update, branch resolution and a
// fixed-length wrong-path squash after every taken branch.
module ex_mem_stage #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_mem_if.slave           bus,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              flushing
);

  localparam int unsigned CNT_W = 3;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORR = 4'h3;
  localparam logic [3:0] OP_LSL = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_SET = 4'h6;
  localparam logic [3:0] OP_LDR = 4'h7;
  localparam logic [3:0] OP_STR = 4'h8;
  localparam logic [3:0] OP_B   = 4'h9;
  localparam logic [3:0] OP_BEQ = 4'hA;
  localparam logic [3:0] OP_BGE = 4'hB;

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic              c_q, c_d;
  logic              bt_q, bt_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              fl_q, fl_d;
  logic              take;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      sd_q     <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      bt_q     <= 1'b0;
      tgt_q    <= '0;
      fl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      sd_q     <= sd_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      bt_q     <= bt_d;
      tgt_q    <= tgt_d;
      fl_q     <= fl_d;
    end
  end

  // Next-state: stall freezes everything; branches resolve on pre-edge flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    rd_d     = rd_q;
    result_d = result_q;
    sd_d     = sd_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    bt_d     = 1'b0;
    tgt_d    = tgt_q;
    fl_d     = fl_q;
    take     = 1'b0;

    if (!bus.stall) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (bus.in_valid) begin
            rd_d     = bus.in_rd;
            result_d = bus.alu_out;
            sd_d     = bus.in_store_data;
            case (bus.in_op)
              OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LSL, OP_SET: begin
                valid_d = 1'b1;
                rw_d    = 1'b1;
              end
              OP_LDR: begin
                valid_d = 1'b1;
                rw_d    = 1'b1;
                mr_d    = 1'b1;
              end
              OP_STR: begin
                valid_d = 1'b1;
                mw_d    = 1'b1;
              end
              OP_CMP: begin
                valid_d = 1'b1;
                z_d     = bus.zero;
                n_d     = bus.negative;
                c_d     = bus.carry;
              end
              OP_B: begin
                valid_d = 1'b1;
                take    = 1'b1;
              end
              OP_BEQ: begin
                valid_d = 1'b1;
                take    = z_q;
              end
              OP_BGE: begin
                valid_d = 1'b1;
                take    = !n_q;
              end
              default: ;
            endcase
            if (take) begin
              bt_d    = 1'b1;
              tgt_d   = bus.in_target;
              state_d = ST_FLUSH;
              cnt_d   = CNT_W'(FLUSH_CYCLES);
              fl_d    = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Every non-stalled slot is squashed, valid or not
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            fl_d    = 1'b0;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
          fl_d    = 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = !bus.stall;
  assign bus.out_valid      = valid_q;
  assign bus.out_reg_write  = rw_q;
  assign bus.out_mem_read   = mr_q;
  assign bus.out_mem_write  = mw_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_result     = result_q;
  assign bus.out_store_data = sd_q;

  assign flag_z        = z_q;
  assign flag_n        = n_q;
  assign flag_c        = c_q;
  assign branch_taken  = bt_q;
  assign branch_target = tgt_q;
  assign flushing      = fl_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized checks of ex_mem_stage against a behavioural
// model of the stage's observable outputs.
module tb_ex_mem_stage;
  localparam int unsigned DW = 32;
  localparam int FLUSH = 2;

  logic clk;
  logic rst_n;
  logic flag_z, flag_n, flag_c, branch_taken, flushing;
  logic [DW-1:0] branch_target;

  ex_mem_if #(.DATA_W(DW)) bus ();

  ex_mem_stage #(.DATA_W(DW), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flushing(flushing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic m_valid, m_rw, m_mr, m_mw, m_z, m_n, m_c, m_bt, m_fl;
  logic [3:0] m_rd;
  logic [DW-1:0] m_res, m_sd, m_tgt;
  int m_left;

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_z = 0; m_n = 0; m_c = 0;
    m_bt = 0; m_fl = 0; m_rd = 0; m_res = 0; m_sd = 0; m_tgt = 0; m_left = 0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] op, input logic [3:0] rd,
                            input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                            input logic [DW-1:0] tgt, input logic z, input logic n,
                            input logic c, input logic st);
    int o;
    bit taken;
    m_bt = 0;
    if (st) return;
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    if (m_left > 0) begin
      m_left = m_left - 1;
      m_fl = (m_left > 0);
      return;
    end
    if (!v) return;
    o = int'(op);
    m_rd = rd; m_res = alu; m_sd = sd;
    m_valid = (o <= 11);
    m_rw = (o <= 4 && o != 5) || o == 6 || o == 7;
    m_mr = (o == 7);
    m_mw = (o == 8);
    taken = (o == 9) || (o == 10 && m_z) || (o == 11 && !m_n);
    if (o == 5) begin m_z = z; m_n = n; m_c = c; end
    if (taken) begin
      m_bt = 1; m_tgt = tgt; m_left = FLUSH; m_fl = 1;
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, settle after it
  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                       input logic [DW-1:0] tgt, input logic z, input logic n,
                       input logic c, input logic st);
    bus.in_valid = v; bus.in_op = op; bus.in_rd = rd; bus.alu_out = alu;
    bus.in_store_data = sd; bus.in_target = tgt; bus.zero = z; bus.negative = n;
    bus.carry = c; bus.stall = st;
    @(posedge clk);
    model_edge(v, op, rd, alu, sd, tgt, z, n, c, st);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1, 4'h0, 4'h7, 32'h1234, 32'h55, 32'h99, 1, 1, 1, 0);
    n_checks++; if ({bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write} !== 4'b0)
      $display("FAIL reset_strobes got=%b exp=0000", {bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}); else n_pass++;
    n_checks++; if ({bus.out_rd, bus.out_result, bus.out_store_data} !== '0)
      $display("FAIL reset_data got rd=%0h res=%0h sd=%0h exp=0", bus.out_rd, bus.out_result, bus.out_store_data); else n_pass++;
    n_checks++; if ({flag_z, flag_n, flag_c, branch_taken, flushing, branch_target} !== '0)
      $display("FAIL reset_ctrl got flags=%b bt=%b fl=%b tgt=%0h exp=0", {flag_z, flag_n, flag_c}, branch_taken, flushing, branch_target); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    drive(1, 4'h0, 4'd3, 32'h0000_0005, 32'h0, 32'h0, 1, 1, 1, 0);
    n_checks++; if ({bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write} !== 4'b1100)
      $display("FAIL add_strobes got=%b exp=1100", {bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}); else n_pass++;
    n_checks++; if (bus.out_rd !== 4'd3 || bus.out_result !== 32'd5)
      $display("FAIL add_data got rd=%0d res=%0h exp rd=3 res=5", bus.out_rd, bus.out_result); else n_pass++;
    n_checks++; if ({flag_z, flag_n, flag_c} !== 3'b000)
      $display("FAIL add_flags got=%b exp=000", {flag_z, flag_n, flag_c}); else n_pass++;
  endtask

  task automatic test_cmp_beq();
    drive(1, 4'h5, 4'd1, 32'h0, 32'h0, 32'h0, 1, 0, 1, 0);
    n_checks++; if ({flag_z, flag_n, flag_c} !== 3'b101 || {bus.out_valid, bus.out_reg_write} !== 2'b10)
      $display("FAIL cmp_flags got flags=%b v/rw=%b exp 101/10", {flag_z, flag_n, flag_c}, {bus.out_valid, bus.out_reg_write}); else n_pass++;
    drive(1, 4'hA, 4'd2, 32'h0, 32'h0, 32'h40, 0, 1, 0, 0);
    n_checks++; if (branch_taken !== 1'b1 || branch_target !== 32'h40 || flushing !== 1'b1)
      $display("FAIL beq_taken got bt=%b tgt=%0h fl=%b exp 1/40/1", branch_taken, branch_target, flushing); else n_pass++;
    drive(1, 4'h0, 4'd4, 32'h11, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (branch_taken !== 1'b0 || bus.out_valid !== 1'b0 || flushing !== 1'b1)
      $display("FAIL beq_flush1 got bt=%b v=%b fl=%b exp 0/0/1", branch_taken, bus.out_valid, flushing); else n_pass++;
    drive(1, 4'h0, 4'd5, 32'h22, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b0 || flushing !== 1'b0)
      $display("FAIL beq_flush2 got v=%b fl=%b exp 0/0", bus.out_valid, flushing); else n_pass++;
    drive(1, 4'h0, 4'd6, 32'h33, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 4'd6 || bus.out_result !== 32'h33)
      $display("FAIL beq_resume got v=%b rd=%0d res=%0h exp 1/6/33", bus.out_valid, bus.out_rd, bus.out_result); else n_pass++;
  endtask

  task automatic test_bge_not_taken();
    drive(1, 4'h5, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0);
    drive(1, 4'hB, 4'd0, 32'h0, 32'h0, 32'h80, 0, 0, 0, 0);
    n_checks++; if (branch_taken !== 1'b0 || flushing !== 1'b0 || {bus.out_valid, bus.out_reg_write} !== 2'b10)
      $display("FAIL bge_not_taken got bt=%b fl=%b v/rw=%b exp 0/0/10", branch_taken, flushing, {bus.out_valid, bus.out_reg_write}); else n_pass++;
    drive(1, 4'h1, 4'd9, 32'h77, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 4'd9 || flag_n !== 1'b1)
      $display("FAIL bge_next got v=%b rd=%0d n=%b exp 1/9/1", bus.out_valid, bus.out_rd, flag_n); else n_pass++;
  endtask

  task automatic test_ldr_stall();
    drive(1, 4'h7, 4'd8, 32'hDEAD, 32'h0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h5, 4'd1, 32'hBEEF, 32'h0, 32'h0, 1, 0, 1, 1);
      n_checks++; if (bus.out_mem_read !== 1'b1 || bus.out_result !== 32'hDEAD || bus.in_ready !== 1'b0)
        $display("FAIL ldr_hold%0d got mr=%b res=%0h rdy=%b exp 1/dead/0", i, bus.out_mem_read, bus.out_result, bus.in_ready); else n_pass++;
      n_checks++; if ({flag_z, flag_n, flag_c} !== 3'b010)
        $display("FAIL ldr_flags%0d got=%b exp=010", i, {flag_z, flag_n, flag_c}); else n_pass++;
    end
    drive(1, 4'h2, 4'd2, 32'hF0, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (bus.out_mem_read !== 1'b0 || bus.out_reg_write !== 1'b1 || bus.in_ready !== 1'b1)
      $display("FAIL ldr_release got mr=%b rw=%b rdy=%b exp 0/1/1", bus.out_mem_read, bus.out_reg_write, bus.in_ready); else n_pass++;
  endtask

  task automatic test_b_stall_flush();
    drive(1, 4'h9, 4'd0, 32'h0, 32'h0, 32'h100, 0, 0, 0, 0);
    n_checks++; if (branch_taken !== 1'b1 || branch_target !== 32'h100)
      $display("FAIL b_taken got bt=%b tgt=%0h exp 1/100", branch_taken, branch_target); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'h0, 4'd1, 32'h1, 32'h0, 32'h0, 0, 0, 0, 1);
      n_checks++; if (flushing !== 1'b1 || branch_taken !== 1'b0)
        $display("FAIL b_stall%0d got fl=%b bt=%b exp 1/0", i, flushing, branch_taken); else n_pass++;
    end
    drive(1, 4'h0, 4'd1, 32'h1, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (flushing !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL b_flush1 got fl=%b v=%b exp 1/0", flushing, bus.out_valid); else n_pass++;
    drive(0, 4'h0, 4'd1, 32'h1, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (flushing !== 1'b0)
      $display("FAIL b_flush2 got fl=%b exp 0", flushing); else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    drive(1, 4'h5, 4'd0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0);
    drive(1, 4'h9, 4'd0, 32'h0, 32'h0, 32'h200, 0, 0, 0, 0);
    n_checks++; if (flag_z !== 1'b1 || flushing !== 1'b1)
      $display("FAIL rst_pre got z=%b fl=%b exp 1/1", flag_z, flushing); else n_pass++;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (flag_z !== 1'b0 || flushing !== 1'b0 || branch_taken !== 1'b0 || branch_target !== '0)
      $display("FAIL rst_async got z=%b fl=%b bt=%b tgt=%0h exp 0", flag_z, flushing, branch_taken, branch_target); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 4'h0, 4'd7, 32'hABC, 32'h0, 32'h0, 0, 0, 0, 0);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 4'd7 || bus.out_result !== 32'hABC)
      $display("FAIL rst_first_add got v=%b rd=%0d res=%0h exp 1/7/abc", bus.out_valid, bus.out_rd, bus.out_result); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            DW'($urandom), DW'($urandom), DW'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0));
      n_checks++;
      if ({bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write} !== {m_valid, m_rw, m_mr, m_mw})
        $display("FAIL rand_strobes[%0d] got=%b exp=%b", i,
                 {bus.out_valid, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}, {m_valid, m_rw, m_mr, m_mw});
      else n_pass++;
      n_checks++;
      if ({flag_z, flag_n, flag_c} !== {m_z, m_n, m_c})
        $display("FAIL rand_flags[%0d] got=%b exp=%b", i, {flag_z, flag_n, flag_c}, {m_z, m_n, m_c});
      else n_pass++;
      n_checks++;
      if (branch_taken !== m_bt || branch_target !== m_tgt || flushing !== m_fl || bus.in_ready !== !bus.stall)
        $display("FAIL rand_branch[%0d] got bt=%b tgt=%0h fl=%b rdy=%b exp bt=%b tgt=%0h fl=%b", i,
                 branch_taken, branch_target, flushing, bus.in_ready, m_bt, m_tgt, m_fl);
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (bus.out_rd !== m_rd || bus.out_result !== m_res || bus.out_store_data !== m_sd)
          $display("FAIL rand_data[%0d] got rd=%0h res=%0h sd=%0h exp rd=%0h res=%0h sd=%0h", i,
                   bus.out_rd, bus.out_result, bus.out_store_data, m_rd, m_res, m_sd);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_op = 0; bus.in_rd = 0; bus.alu_out = 0;
    bus.in_store_data = 0; bus.in_target = 0; bus.zero = 0; bus.negative = 0;
    bus.carry = 0; bus.stall = 0;
    test_reset();
    test_add();
    test_cmp_beq();
    test_bge_not_taken();
    test_ldr_stall();
    test_b_stall_flush();
    test_reset_mid_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, wrong-path slots squashed after a taken branch (legal range 1-7).
REQ-003 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports alu_out  in  DATA_W  ALU result; zero, negative, carry  in  1 each  ALU flags.
REQ-006 SHALL have ports in_valid  in  1; in_op  in  4  ALU select code; in_rd  in  4  dest reg; in_store_data  in  DATA_W; in_target  in  DATA_W  branch target.
REQ-007 SHALL have port stall  in  1  memory stage not ready; in_ready  out  1  = !stall.
REQ-008 SHALL have ports out_valid, out_reg_write, out_mem_read, out_mem_write  out  1 each; out_rd  out  4; out_result, out_store_data  out  DATA_W.
REQ-009 SHALL have ports flag_z, flag_n, flag_c  out  1 each  architectural flags.
REQ-010 SHALL have ports branch_taken  out  1  single-cycle pulse; branch_target  out  DATA_W; flushing  out  1  high in FLUSH state.

Function
REQ-011 SHALL decode in_op: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 LSL, 0101 CMP, 0110 SET, 0111 LDR, 1000 STR, 1001 B, 1010 BEQ, 1011 BGE, other = NOP.
REQ-012 SHALL accept an instruction on a rising edge when in_valid && !stall && state==RUN.
REQ-013 SHALL, on accept, register out_valid=1, out_rd, out_result=alu_out, out_store_data, out_reg_write=1 for ADD/SUB/AND/OR/LSL/SET/LDR, out_mem_read=1 for LDR only, out_mem_write=1 for STR only.
REQ-014 SHALL, on accept of CMP, load flag_z/flag_n/flag_c from zero/negative/carry in the same edge; no other op changes flags.
REQ-015 SHALL, on accept of CMP, register out_valid=1 with all write/mem strobes 0.
REQ-016 SHALL resolve branches at accept using flag registers as held before that edge: B always taken; BEQ taken iff flag_z==1; BGE taken iff flag_n==0.
REQ-017 SHALL, for a taken branch, assert branch_taken for exactly one cycle after the accepting edge with branch_target=in_target, and enter FLUSH with counter=FLUSH_CYCLES.
REQ-018 SHALL register out_valid=1 with all strobes 0 for any branch (taken or not) and for NOP opcodes out_valid=0.
REQ-019 SHALL, in FLUSH, discard every in_valid slot while !stall, decrementing the counter per discarded slot (in_valid=0 cycles with !stall also decrement); return to RUN the edge counter reaches 0.
REQ-020 SHALL, while in FLUSH, drive out_valid=0 and never update flags.
REQ-021 SHALL, while stall=1, hold all out_* registers, flags, state and counter unchanged; branch_taken stays 0.
REQ-022 SHALL, when !stall and no accept in RUN, register out_valid=0 and all strobes 0 (bubble).
REQ-023 SHALL keep branch_taken combinationally independent of inputs (registered output).
REQ-024 SHALL treat a CMP accepted on edge k and BEQ/BGE accepted on edge k+1 as using the CMP's flags.

Reset
REQ-025 SHALL, while rst_n=0, force state=RUN, counter=0, out_valid=0, all strobes 0, out_rd=0, out_result=0, out_store_data=0, flags=0, branch_taken=0, branch_target=0, flushing=0.
REQ-026 SHALL, when reset asserts mid-FLUSH or mid-stall, abandon the operation; first edge after release accepts normally.

Verification
REQ-027 ADD with alu_out=0x0000_0005, rd=3, no stall -> next cycle out_valid=1, out_reg_write=1, out_rd=3, out_result=5, flags unchanged.
REQ-028 CMP with zero=1,negative=0 then BEQ target=0x40 next cycle -> flag_z=1, branch_taken pulse 1 cycle, branch_target=0x40, flushing=1 for 2 cycles, 2 following valid instructions produce out_valid=0.
REQ-029 BGE with flag_n=1 -> branch_taken stays 0, no FLUSH, next instruction accepted.
REQ-030 LDR accepted then stall=1 for 3 cycles -> out_mem_read=1 and out_result held 3 cycles, in_ready=0, flags unchanged.
REQ-031 B taken, stall=1 during FLUSH -> counter frozen; flushing deasserts only after 2 non-stalled cycles.
REQ-032 rst_n low mid-FLUSH after CMP set flag_z=1 -> flag_z=0, flushing=0 immediately; first post-reset ADD accepted.
